mem_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the RISC-V core's instruction-fetch port and its load/store port. It sits between the core (multicycle or pipelined) and the memory model. Each requester uses a req/ack handshake, and the arbiter runs an issue/wait/respond state machine sized to the memory's read latency. It replaces the separate instruction and data memories when the core is built against a unified memory.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner types and latency limit for the unified-memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} mem_arb_state_e;
    typedef enum logic {OWN_I, OWN_D} mem_arb_owner_e;
    localparam int MEM_ARB_LAT_MAX = 15;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational winner select between fetch and data requests.
// MEM_ARBITER_RR_EN selects round-robin on ties; otherwise the data port always wins.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic           i_req,
    input  logic           d_req,
`ifdef MEM_ARBITER_RR_EN
    input  mem_arb_owner_e last,
`endif
    output mem_arb_owner_e owner,
    output logic           valid
);
    assign valid = i_req | d_req;
`ifdef MEM_ARBITER_RR_EN
    assign owner = (i_req && d_req) ? ((last == OWN_D) ? OWN_I : OWN_D) : (d_req ? OWN_D : OWN_I);
`else
    assign owner = d_req ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store ports via an
// IDLE/ISSUE/WAIT/ACK FSM; define MEM_ARBITER_RR_EN for round-robin tie breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_ARB_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    mem_arb_state_e state, next;
    mem_arb_owner_e owner, pick_owner;
    logic [CNT_W-1:0] cnt;
    logic pick_valid, grant, capture;

`ifdef MEM_ARBITER_RR_EN
    mem_arb_owner_e rr;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            rr <= OWN_D;
        else if (grant)
            rr <= pick_owner;
`endif

    mem_arbiter_pick u_pick (
        .i_req(i_req),
        .d_req(d_req),
`ifdef MEM_ARBITER_RR_EN
        .last(rr),
`endif
        .owner(pick_owner),
        .valid(pick_valid)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= next;

    // mem_we doubles as the latched store flag while in ISSUE
    always_comb begin
        grant   = state == IDLE && pick_valid;
        capture = state == WAIT && cnt == '0;
        next    = (state == IDLE)  ? (pick_valid ? ISSUE : IDLE) :
                  (state == ISSUE) ? (mem_we ? ACK : WAIT) :
                  (state == WAIT)  ? (capture ? ACK : WAIT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            owner     <= OWN_D;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if (grant) begin
                owner     <= pick_owner;
                mem_we    <= pick_owner == OWN_D && d_we;
                mem_addr  <= (pick_owner == OWN_D) ? d_addr : i_addr;
                mem_wdata <= d_wdata;
            end else if (state == ISSUE) begin
                mem_we <= 1'b0;
            end
            cnt     <= (state == ISSUE && !mem_we) ? LAT_M1 :
                       (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            mem_en  <= next == ISSUE;
            busy    <= next != IDLE;
            i_ack   <= next == ACK && state != ACK && owner == OWN_I;
            d_ack   <= next == ACK && state != ACK && owner == OWN_D;
            i_rdata <= (capture && owner == OWN_I) ? mem_rdata : '0;
            d_rdata <= (capture && owner == OWN_D) ? mem_rdata : '0;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench driving two arbiters (MEM_LAT=1 and MEM_LAT=3) with
// identical request streams; every mem_en and every ack must match a queued expectation.
module tb_mem_arbiter;
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} rq_t;
    typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata;} mx_t;
    typedef struct {int cyc; bit d; logic [31:0] data;} ax_t;
    typedef struct {bit d; bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [31:0] mem [2][256];
    rq_t qi [2][$];
    rq_t qd [2][$];
    mx_t mq [2][$];
    ax_t aq [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int L = (k == 0) ? 1 : 3;
        logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
        logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
        logic i_ack, d_ack, mem_en, mem_we, busy, any_out;
        logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
        logic [7:0] la = '0;
        int mc = 0;
        logic was_ack = 1'b0;
        rq_t r;
        mx_t m;
        ax_t a;

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata), .d_ack(d_ack),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy)
        );

        assign any_out = |{i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy};
        // read data is only valid exactly MEM_LAT cycles after the strobe
        assign mem_rdata = (mc == L) ? mem[k][la] : 32'hdeadbeef;

        always @(posedge clk or posedge rst)
            if (rst)
                mc <= 0;
            else if (mem_en) begin
                la <= mem_addr[9:2];
                mc <= 1;
                if (mem_we) mem[k][mem_addr[9:2]] <= mem_wdata;
            end else if (mc != 0 && mc < 31)
                mc <= mc + 1;

        always @(negedge clk) begin
            if (rst || i_ack) i_req = 1'b0;
            if (rst || d_ack) d_req = 1'b0;
            if (!rst && !i_req && qi[k].size() > 0) begin
                r = qi[k].pop_front();
                i_req = 1'b1;
                i_addr = r.addr;
            end
            if (!rst && !d_req && qd[k].size() > 0) begin
                r = qd[k].pop_front();
                d_req = 1'b1;
                d_we = r.we;
                d_addr = r.addr;
                d_wdata = r.wdata;
            end
        end

        always @(negedge clk) if (!rst) begin
            if (was_ack) chk($sformatf("lat%0d rdata_clear", L), i_rdata | d_rdata, 32'h0);
            was_ack = i_ack | d_ack;
            if (mem_en) begin
                if (mq[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lat%0d unexpected mem_en: got addr %h expected none (cycle %0d)", L, mem_addr, cyc);
                end else begin
                    m = mq[k].pop_front();
                    chk($sformatf("lat%0d mem_en_cycle", L), cyc, m.cyc);
                    chk($sformatf("lat%0d mem_addr", L), mem_addr, m.addr);
                    chk($sformatf("lat%0d mem_we", L), {31'h0, mem_we}, {31'h0, m.we});
                    if (m.we) chk($sformatf("lat%0d mem_wdata", L), mem_wdata, m.wdata);
                    chk($sformatf("lat%0d busy", L), {31'h0, busy}, 32'h1);
                end
            end
            if (i_ack || d_ack) begin
                if (aq[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lat%0d unexpected ack: got i_ack=%b d_ack=%b expected none (cycle %0d)", L, i_ack, d_ack, cyc);
                end else begin
                    a = aq[k].pop_front();
                    chk($sformatf("lat%0d ack_cycle", L), cyc, a.cyc);
                    chk($sformatf("lat%0d ack_port", L), {30'h0, i_ack, d_ack}, a.d ? 32'h1 : 32'h2);
                    chk($sformatf("lat%0d rdata", L), a.d ? d_rdata : i_rdata, a.data);
                end
            end
        end
    end

    task automatic put(int k, bit d, bit we, logic [31:0] addr, logic [31:0] wd);
        if (d) qd[k].push_back('{addr, we, wd});
        else qi[k].push_back('{addr, 1'b0, 32'h0});
    endtask

    // s is the cycle in which the request is first sampled in IDLE
    task automatic exp_tx(int k, bit d, bit we, logic [31:0] addr, logic [31:0] wd, logic [31:0] rd, int s);
        int l = (k == 0) ? 1 : 3;
        mq[k].push_back('{s + 1, we, addr, wd});
        aq[k].push_back('{we ? s + 2 : s + 2 + l, d, we ? 32'h0 : rd});
    endtask

    task automatic at_cycle(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(int n);
        repeat (n) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("inst%0d pending_mem_en", k), mq[k].size(), 0);
            chk($sformatf("inst%0d pending_ack", k), aq[k].size(), 0);
        end
        chk("busy_idle", {30'h0, g[1].busy, g[0].busy}, 32'h0);
    endtask

    vec_t vt [9];
    int t0;
    int s;
    bit ord [8];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 256; j++) mem[k][j] = 32'ha5a50000 | j;
            mem[k][4] = 32'h00627033;
        end
        vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'h00627033};
        vt[1] = '{1'b1, 1'b1, 32'h40, 32'hff, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'hff};
        vt[3] = '{1'b0, 1'b0, 32'h40, 32'h0, 32'hff};
        vt[4] = '{1'b1, 1'b1, 32'h0, 32'h12345678, 32'h0};
        vt[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678};
        vt[6] = '{1'b1, 1'b0, 32'h8, 32'h0, 32'ha5a50002};
        vt[7] = '{1'b1, 1'b1, 32'hfc, 32'hcafef00d, 32'h0};
        vt[8] = '{1'b1, 1'b0, 32'hfc, 32'h0, 32'hcafef00d};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_lat1", {31'h0, g[0].any_out}, 32'h0);
        chk("reset_outputs_lat3", {31'h0, g[1].any_out}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // both ports held with four requests each; pointer is fresh from reset
        t0 = cyc;
        for (int n = 0; n < 8; n++)
`ifdef MEM_ARBITER_RR_EN
            ord[n] = n[0];
`else
            ord[n] = n < 4;
`endif
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 4; n++) begin
                put(k, 1'b0, 1'b0, 32'h10, 32'h0);
                put(k, 1'b1, 1'b0, 32'h20, 32'h0);
            end
            s = t0;
            for (int n = 0; n < 8; n++) begin
                exp_tx(k, ord[n], 1'b0, ord[n] ? 32'h20 : 32'h10, 32'h0,
                       ord[n] ? 32'ha5a50008 : 32'h00627033, s);
                s += (k == 0) ? 4 : 6;
            end
        end
        drain(60);

        for (int v = 0; v < 9; v++) begin
            t0 = cyc;
            for (int k = 0; k < 2; k++) begin
                put(k, vt[v].d, vt[v].we, vt[v].addr, vt[v].wdata);
                exp_tx(k, vt[v].d, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].rdata, t0);
            end
            drain(10);
        end

        // back-to-back fetches with i_req held
        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            put(k, 1'b0, 1'b0, 32'h0, 32'h0);
            put(k, 1'b0, 1'b0, 32'h4, 32'h0);
            put(k, 1'b0, 1'b0, 32'h8, 32'h0);
            s = t0;
            exp_tx(k, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, s);
            s += (k == 0) ? 4 : 6;
            exp_tx(k, 1'b0, 1'b0, 32'h4, 32'h0, 32'ha5a50001, s);
            s += (k == 0) ? 4 : 6;
            exp_tx(k, 1'b0, 1'b0, 32'h8, 32'h0, 32'ha5a50002, s);
        end
        drain(20);

        // fetch request rising while a data load is in WAIT
        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            put(k, 1'b1, 1'b0, 32'h20, 32'h0);
            exp_tx(k, 1'b1, 1'b0, 32'h20, 32'h0, 32'ha5a50008, t0);
        end
        at_cycle(t0 + 2);
        for (int k = 0; k < 2; k++) begin
            put(k, 1'b0, 1'b0, 32'h10, 32'h0);
            exp_tx(k, 1'b0, 1'b0, 32'h10, 32'h0, 32'h00627033, t0 + ((k == 0) ? 4 : 6));
        end
        drain(20);

        // reset during WAIT abandons the load without an ack
        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            put(k, 1'b1, 1'b0, 32'h20, 32'h0);
            mq[k].push_back('{t0 + 1, 1'b0, 32'h20, 32'h0});
        end
        at_cycle(t0 + 2);
        rst = 1'b1;
        #1;
        chk("midreset_outputs_lat1", {31'h0, g[0].any_out}, 32'h0);
        chk("midreset_outputs_lat3", {31'h0, g[1].any_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drain(10);

        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            put(k, 1'b0, 1'b0, 32'h10, 32'h0);
            exp_tx(k, 1'b0, 1'b0, 32'h10, 32'h0, 32'h00627033, t0);
        end
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
